decode_queue: RTL and testbench

- Decode stage for the out-of-order RV32I core. Sits between instruction fetch and dispatch.
- Accepts raw instruction+PC from fetch via valid/ready and decodes it combinationally on entry.
- Stores the decoded record in a DEPTH-entry FIFO and presents the FIFO head to dispatch via valid/ready.
- Adds over the plain decoder: buffering, illegal-instruction detection, register-field cleanup, flush, global stall, parametrised widths.

---
 rtl/decode_queue_pkg.sv | 62 ++++++
 rtl/decode_queue_inst_decode_core.sv | 168 ++++++++++++++++
 rtl/decode_queue.sv | 95 +++++++++
 tb/tb_decode_queue.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared decode constants, operation enum and decoded-record type.
// The MUL/DIV enum values exist always; DECODE_RV32M_EN gates their decoding.
package decode_queue_pkg;

   localparam int OPENUM_W = 6;
   localparam int REG_W    = 5;

   localparam int OPC_LSB = 0;
   localparam int RD_LSB  = 7;
   localparam int F3_LSB  = 12;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int F7_LSB  = 25;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_ARITH  = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [OPENUM_W-1:0] {
      OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW,
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
      OP_SLLI, OP_SRLI, OP_SRAI,
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } openum_e;

   typedef struct packed {
      openum_e          op;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic             is_jump;
      logic             is_store;
      logic             is_load;
      logic             illegal;
   } dec_rec_t;

endpackage

// File: rtl/decode_queue_inst_decode_core.sv
// Combinational RV32I decoder: raw instruction -> decoded record + immediate.
// DECODE_RV32M_EN adds the MUL/DIV group; otherwise that encoding is illegal.
module inst_decode_core
   import decode_queue_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output dec_rec_t        rec,
   output logic [XLEN-1:0] imm
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
   logic [31:0] imm32;
   logic        bad;

   assign opc = inst[OPC_LSB +: 7];
   assign f3  = inst[F3_LSB +: 3];
   assign f7  = inst[F7_LSB +: 7];

   assign i_imm = {{20{inst[31]}}, inst[31:20]};
   assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign b_imm = {{19{inst[31]}}, inst[31], inst[7],
                   inst[30:25], inst[11:8], 1'b0};
   assign u_imm = {inst[31:12], 12'b0};
   assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12],
                   inst[20], inst[30:21], 1'b0};

   always_comb begin
      rec     = '0;
      imm32   = '0;
      bad     = 1'b0;
      rec.rd  = inst[RD_LSB +: REG_W];
      rec.rs1 = inst[RS1_LSB +: REG_W];
      rec.rs2 = inst[RS2_LSB +: REG_W];
      unique case (1'b1)
         (opc == OPC_LUI), (opc == OPC_AUIPC): begin
            rec.op  = (opc == OPC_LUI) ? OP_LUI : OP_AUIPC;
            rec.rs1 = '0;
            rec.rs2 = '0;
            imm32   = u_imm;
         end
         (opc == OPC_JAL): begin
            rec.op      = OP_JAL;
            rec.rs1     = '0;
            rec.rs2     = '0;
            rec.is_jump = 1'b1;
            imm32       = j_imm;
         end
         (opc == OPC_JALR): begin
            rec.op      = OP_JALR;
            rec.rs2     = '0;
            rec.is_jump = 1'b1;
            imm32       = i_imm;
            bad         = (f3 != 3'b000);
         end
         (opc == OPC_BRANCH): begin
            rec.rd      = '0;
            rec.is_jump = 1'b1;
            imm32       = b_imm;
            case (f3)
               3'b000:  rec.op = OP_BEQ;
               3'b001:  rec.op = OP_BNE;
               3'b100:  rec.op = OP_BLT;
               3'b101:  rec.op = OP_BGE;
               3'b110:  rec.op = OP_BLTU;
               3'b111:  rec.op = OP_BGEU;
               default: bad = 1'b1;
            endcase
         end
         (opc == OPC_LOAD): begin
            rec.rs2     = '0;
            rec.is_load = 1'b1;
            imm32       = i_imm;
            case (f3)
               3'b000:  rec.op = OP_LB;
               3'b001:  rec.op = OP_LH;
               3'b010:  rec.op = OP_LW;
               3'b100:  rec.op = OP_LBU;
               3'b101:  rec.op = OP_LHU;
               default: bad = 1'b1;
            endcase
         end
         (opc == OPC_STORE): begin
            rec.rd       = '0;
            rec.is_store = 1'b1;
            imm32        = s_imm;
            case (f3)
               3'b000:  rec.op = OP_SB;
               3'b001:  rec.op = OP_SH;
               3'b010:  rec.op = OP_SW;
               default: bad = 1'b1;
            endcase
         end
         (opc == OPC_IMM): begin
            rec.rs2 = '0;
            imm32   = i_imm;
            case (f3)
               F3_ADD:  rec.op = OP_ADDI;
               F3_SLT:  rec.op = OP_SLTI;
               F3_SLTU: rec.op = OP_SLTIU;
               F3_XOR:  rec.op = OP_XORI;
               F3_OR:   rec.op = OP_ORI;
               F3_AND:  rec.op = OP_ANDI;
               F3_SLL: begin
                  rec.op = OP_SLLI;
                  imm32  = {27'b0, inst[24:20]};
                  bad    = (f7 != F7_BASE);
               end
               default: begin
                  rec.op = (f7 == F7_ALT) ? OP_SRAI : OP_SRLI;
                  imm32  = {27'b0, inst[24:20]};
                  bad    = (f7 != F7_BASE) && (f7 != F7_ALT);
               end
            endcase
         end
         (opc == OPC_ARITH): begin
            if (f7 == F7_BASE) begin
               case (f3)
                  F3_ADD:  rec.op = OP_ADD;
                  F3_SLL:  rec.op = OP_SLL;
                  F3_SLT:  rec.op = OP_SLT;
                  F3_SLTU: rec.op = OP_SLTU;
                  F3_XOR:  rec.op = OP_XOR;
                  F3_SR:   rec.op = OP_SRL;
                  F3_OR:   rec.op = OP_OR;
                  default: rec.op = OP_AND;
               endcase
            end else if (f7 == F7_ALT) begin
               case (f3)
                  F3_ADD:  rec.op = OP_SUB;
                  F3_SR:   rec.op = OP_SRA;
                  default: bad = 1'b1;
               endcase
`ifdef DECODE_RV32M_EN
            end else if (f7 == F7_MULDIV) begin
               case (f3)
                  3'b000:  rec.op = OP_MUL;
                  3'b001:  rec.op = OP_MULH;
                  3'b010:  rec.op = OP_MULHSU;
                  3'b011:  rec.op = OP_MULHU;
                  3'b100:  rec.op = OP_DIV;
                  3'b101:  rec.op = OP_DIVU;
                  3'b110:  rec.op = OP_REM;
                  default: rec.op = OP_REMU;
               endcase
`endif
            end else begin
               bad = 1'b1;
            end
         end
         default: bad = 1'b1;
      endcase
      // illegal entries travel down the pipe as a clean NOP carrying only the flag
      if (bad || inst == '0) begin
         rec         = '0;
         rec.op      = OP_NOP;
         rec.illegal = 1'b1;
         imm32       = '0;
      end
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes fetch output on entry and buffers it in a DEPTH-entry FIFO.
// Build with DECODE_RV32M_EN to decode the RV32M multiply/divide group.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rdy,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_inst,
   input  logic [ADDR_W-1:0]      in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OPENUM_W-1:0]    out_openum,
   output logic [REG_W-1:0]       out_rd,
   output logic [REG_W-1:0]       out_rs1,
   output logic [REG_W-1:0]       out_rs2,
   output logic [XLEN-1:0]        out_imm,
   output logic [ADDR_W-1:0]      out_pc,
   output logic                   out_is_jump,
   output logic                   out_is_store,
   output logic                   out_is_load,
   output logic                   out_illegal,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  head, tail;
   logic              enq, deq;
   dec_rec_t          dec_rec;
   logic [XLEN-1:0]   dec_imm;
   dec_rec_t          rec_q [DEPTH];
   logic [XLEN-1:0]   imm_q [DEPTH];
   logic [ADDR_W-1:0] pc_q  [DEPTH];

   inst_decode_core #(.XLEN(XLEN)) u_dec (
      .inst (in_inst),
      .rec  (dec_rec),
      .imm  (dec_imm)
   );

   // full blocks enqueue even when the head leaves in the same cycle
   assign in_ready  = rst_n & rdy & ~flush & (count < CNT_W'(DEPTH));
   assign out_valid = rst_n & rdy & ~flush & (count != '0);
   assign enq       = in_valid & in_ready;
   assign deq       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rdy && flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + PTR_W'(1);
         if (deq) head <= head + PTR_W'(1);
         if (enq && !deq) begin
            count <= count + CNT_W'(1);
         end else if (deq && !enq) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         rec_q[tail] <= dec_rec;
         imm_q[tail] <= dec_imm;
         pc_q[tail]  <= in_pc;
      end
   end

   assign out_openum   = rec_q[head].op;
   assign out_rd       = rec_q[head].rd;
   assign out_rs1      = rec_q[head].rs1;
   assign out_rs2      = rec_q[head].rs2;
   assign out_imm      = imm_q[head];
   assign out_pc       = pc_q[head];
   assign out_is_jump  = rec_q[head].is_jump;
   assign out_is_store = rec_q[head].is_store;
   assign out_is_load  = rec_q[head].is_load;
   assign out_illegal  = rec_q[head].illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: vector table through a scoreboard plus flush/stall/full sequences.
module tb_decode_queue;
   import decode_queue_pkg::*;

   localparam int NV = 22;
   localparam int QD = 4;

   logic        clk = 1'b0;
   logic        rst_n, rdy, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] in_inst, in_pc, out_imm, out_pc;
   logic [5:0]  out_openum;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic        out_is_jump, out_is_store, out_is_load, out_illegal;
   logic [2:0]  count;

   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        j, s, l, ill;
      logic [31:0] pc;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      exp_t        e;
   } vec_t;

   vec_t vec [NV];
   exp_t sb [$];
   exp_t exp_cur;
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   decode_queue dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_openum(out_openum), .out_rd(out_rd),
      .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_imm(out_imm), .out_pc(out_pc),
      .out_is_jump(out_is_jump), .out_is_store(out_is_store),
      .out_is_load(out_is_load), .out_illegal(out_illegal),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, want);
      end
   endtask

   function automatic exp_t mk(input openum_e op, input int rd, input int rs1,
                               input int rs2, input logic [31:0] imm,
                               input logic j, input logic s, input logic l);
      exp_t e;
      e.op = op; e.rd = 5'(rd); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2);
      e.imm = imm; e.j = j; e.s = s; e.l = l; e.ill = 1'b0; e.pc = '0;
      return e;
   endfunction

   function automatic exp_t bad();
      exp_t e;
      e = mk(OP_NOP, 0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      e.ill = 1'b1;
      return e;
   endfunction

   // scoreboard: occupancy/handshake each cycle, contents on every dequeue
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         chk("count", 64'(count), 64'(sb.size()));
         chk("in_ready", 64'(in_ready), 64'(rdy && !flush && sb.size() < QD));
         chk("out_valid", 64'(out_valid), 64'(rdy && !flush && sb.size() != 0));
         if (rdy && flush) begin
            sb.delete();
         end else begin
            if (out_valid && out_ready && sb.size() != 0) begin
               mon_e = sb.pop_front();
               chk("openum", 64'(out_openum), 64'(mon_e.op));
               chk("rd", 64'(out_rd), 64'(mon_e.rd));
               chk("rs1", 64'(out_rs1), 64'(mon_e.rs1));
               chk("rs2", 64'(out_rs2), 64'(mon_e.rs2));
               chk("imm", 64'(out_imm), 64'(mon_e.imm));
               chk("pc", 64'(out_pc), 64'(mon_e.pc));
               chk("flags", 64'({out_is_jump, out_is_store, out_is_load, out_illegal}),
                   64'({mon_e.j, mon_e.s, mon_e.l, mon_e.ill}));
            end
            if (in_valid && in_ready) sb.push_back(exp_cur);
         end
      end
   end

   task automatic enq(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      in_valid = 1'b1; in_inst = inst; in_pc = pc;
      exp_cur = e; exp_cur.pc = pc;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) chk("enq_timeout", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (count != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drained", 64'(count), 64'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0]  = '{32'h00500093, mk(OP_ADDI, 1, 0, 0, 32'd5, 0, 0, 0)};
      vec[1]  = '{32'hFE208EE3, mk(OP_BEQ, 0, 1, 2, 32'hFFFFFFFC, 1, 0, 0)};
      vec[2]  = '{32'h4031D193, mk(OP_SRAI, 3, 3, 0, 32'd3, 0, 0, 0)};
      vec[3]  = '{32'h40319193, bad()};
`ifdef DECODE_RV32M_EN
      vec[4]  = '{32'h02208033, mk(OP_MUL, 0, 1, 2, 32'h0, 0, 0, 0)};
`else
      vec[4]  = '{32'h02208033, bad()};
`endif
      vec[5]  = '{32'h123452B7, mk(OP_LUI, 5, 0, 0, 32'h12345000, 0, 0, 0)};
      vec[6]  = '{32'h008000EF, mk(OP_JAL, 1, 0, 0, 32'd8, 1, 0, 0)};
      vec[7]  = '{32'h00008067, mk(OP_JALR, 0, 1, 0, 32'h0, 1, 0, 0)};
      vec[8]  = '{32'h00009067, bad()};
      vec[9]  = '{32'hFFC1A103, mk(OP_LW, 2, 3, 0, 32'hFFFFFFFC, 0, 0, 1)};
      vec[10] = '{32'h0001B103, bad()};
      vec[11] = '{32'h0020A423, mk(OP_SW, 0, 1, 2, 32'd8, 0, 1, 0)};
      vec[12] = '{32'h0020B423, bad()};
      vec[13] = '{32'h402081B3, mk(OP_SUB, 3, 1, 2, 32'h0, 0, 0, 0)};
      vec[14] = '{32'h4020E1B3, bad()};
      vec[15] = '{32'h00000000, bad()};
      vec[16] = '{32'h0000007F, bad()};
      vec[17] = '{32'h00002063, bad()};
      vec[18] = '{32'hFFFFF517, mk(OP_AUIPC, 10, 0, 0, 32'hFFFFF000, 0, 0, 0)};
      vec[19] = '{32'h01F09093, mk(OP_SLLI, 1, 1, 0, 32'd31, 0, 0, 0)};
      vec[20] = '{32'hFFF08093, mk(OP_ADDI, 1, 1, 0, 32'hFFFFFFFF, 0, 0, 0)};
      vec[21] = '{32'h4062D233, mk(OP_SRA, 4, 5, 6, 32'h0, 0, 0, 0)};

      rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      in_inst = '0; in_pc = '0;
      exp_cur = bad();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      // first-entry latency
      enq(vec[0].inst, 32'h0, vec[0].e);
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("lat_count", 64'(count), 64'd1);
      chk("lat_op", 64'(out_openum), 64'(OP_ADDI));
      drain();

      // table through the scoreboard, dequeued as they arrive
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++)
         enq(vec[i].inst, 32'h100 + 32'(i) * 4, vec[i].e);
      drain();

      // fill to full, fifth held until space appears
      for (int i = 0; i < QD; i++)
         enq(vec[5 + i].inst, 32'h200 + 32'(i) * 4, vec[5 + i].e);
      chk("full_count", 64'(count), 64'd4);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1; in_inst = vec[9].inst; in_pc = 32'h210;
      exp_cur = vec[9].e; exp_cur.pc = 32'h210;
      repeat (3) @(posedge clk);
      #1;
      chk("held_count", 64'(count), 64'd4);
      out_ready = 1'b1;
      enq(vec[9].inst, 32'h210, vec[9].e);
      drain();

      // flush drops queued entries and the flush-cycle offer
      for (int i = 0; i < 3; i++)
         enq(vec[11 + i].inst, 32'h300 + 32'(i) * 4, vec[11 + i].e);
      chk("pre_flush_count", 64'(count), 64'd3);
      in_valid = 1'b1; in_inst = vec[0].inst; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk("flush_after", 64'(count), 64'd0);

      // stall freezes everything
      enq(vec[18].inst, 32'h400, vec[18].e);
      enq(vec[19].inst, 32'h404, vec[19].e);
      rdy = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_inst = vec[20].inst;
      repeat (3) @(posedge clk);
      #1;
      chk("stall_count", 64'(count), 64'd2);
      chk("stall_head_pc", 64'(out_pc), 64'h400);
      chk("stall_out_valid", 64'(out_valid), 64'd0);
      in_valid = 1'b0; rdy = 1'b1;
      drain();
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
